// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data RAM for the LSU.
// Serves byte/half/word(/double) loads and stores with sign/zero extension and
// per-byte write enables. A load's raw word is captured in the cycle it is
// accepted and shaped into rd_o in the following cycle. Accesses that straddle
// a word boundary take a second cycle in the SPLIT state to reach word w+1.
module data_memory_ctrl #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH_BYTES   = 32'h20000,
   parameter int unsigned START_ADDRESS = 32'h00000,
   parameter string       INIT_FILE     = ""
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [31:0]           addr_i,
   input  logic [DATA_WIDTH-1:0] wd_i,
   output logic                  ready_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rd_o,
   output logic                  err_o
);

   localparam int unsigned NB          = DATA_WIDTH / 8;
   localparam int unsigned OFFW        = $clog2(NB);
   localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / NB;
   localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef word_t                 mem_t [DEPTH_WORDS];
   typedef enum logic {S_IDLE, S_SPLIT} state_t;

   // Power-up image: zero everywhere.
   function mem_t init_mem();
      mem_t m;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) m[i] = '0;
      return m;
   endfunction

   // Storage array; deliberately has no reset.
   word_t r_mem [DEPTH_WORDS] = init_mem();

   state_t                  r_state, w_state_next;

   // Access attributes captured on every accept; reused by SPLIT and by the
   // load-shaping logic in the cycle after the read.
   logic                    r_we, r_uns, r_fault, r_split;
   logic [1:0]              r_size;
   logic [OFFW-1:0]         r_off;
   logic [AW-1:0]           r_idx;
   logic [DATA_WIDTH-1:0]   r_wd;

   logic [DATA_WIDTH-1:0]   r_rdata;     // registered read port
   logic [DATA_WIDTH-1:0]   r_lo;        // low word of a split load
   logic [DATA_WIDTH-1:0]   r_rd_hold;   // last delivered load value
   logic                    r_rvalid, r_err;

   logic                    w_idle, w_acc, w_fault, w_split;
   logic [3:0]              w_bytes, w_sel_bytes, w_ld_bytes;
   logic [OFFW-1:0]         w_off_in, w_sel_off;
   logic [AW-1:0]           w_in_idx, w_idx;
   logic [32:0]             w_last;
   logic [1:0]              w_sel_size;
   logic [DATA_WIDTH-1:0]   w_sel_wd, w_wdata, w_val, w_ext, w_ld_data;
   logic [NB-1:0]           w_mask, w_be;
   logic [2*NB-1:0]         w_mask2;
   logic [2*DATA_WIDTH-1:0] w_data2, w_raw2;
   logic                    w_rd_en, w_sign_bit, w_sign;

   // Request decode: size, offset, fault and word-boundary straddle.
   assign w_idle   = (r_state == S_IDLE);
   assign w_acc    = req_i && w_idle && rst_ni;
   assign w_bytes  = 4'd1 << size_i;
   assign w_off_in = addr_i[OFFW-1:0];
   assign w_in_idx = addr_i[OFFW +: AW];
   assign w_last   = {1'b0, addr_i} + {29'd0, w_bytes} - 33'd1;
   assign w_fault  = (w_last >= 33'(DEPTH_BYTES)) ||
                     ((DATA_WIDTH == 32) && (size_i == 2'd3));
   assign w_split  = (5'(w_off_in) + 5'(w_bytes)) > 5'(NB);

   // The single memory port serves the live request in IDLE and the latched
   // request (word w+1) in SPLIT. Lane placement is computed over two words
   // so the low half goes out at accept and the high half in SPLIT.
   assign w_sel_size  = w_idle ? size_i   : r_size;
   assign w_sel_off   = w_idle ? w_off_in : r_off;
   assign w_sel_wd    = w_idle ? wd_i     : r_wd;
   assign w_sel_bytes = 4'd1 << w_sel_size;
   assign w_mask2     = {{NB{1'b0}}, w_mask} << w_sel_off;
   assign w_data2     = {{DATA_WIDTH{1'b0}}, w_sel_wd} << {w_sel_off, 3'b000};
   assign w_idx       = w_idle ? w_in_idx : r_idx + 1'b1;
   assign w_wdata     = w_idle ? w_data2[DATA_WIDTH-1:0] : w_data2[2*DATA_WIDTH-1:DATA_WIDTH];
   assign w_be        = w_idle ? ((w_acc && we_i && !w_fault) ? w_mask2[NB-1:0] : '0)
                               : (r_we ? w_mask2[2*NB-1:NB] : '0);
   assign w_rd_en     = w_idle ? (w_acc && !we_i && !w_fault) : !r_we;

   // Load shaping: merge the split halves, shift down by offset, extend.
   assign w_raw2     = r_split ? {r_rdata, r_lo} : {{DATA_WIDTH{1'b0}}, r_rdata};
   assign w_val      = DATA_WIDTH'(w_raw2 >> {r_off, 3'b000});
   assign w_ld_bytes = 4'd1 << r_size;
   assign w_sign     = w_sign_bit && !r_uns;
   assign w_ld_data  = r_fault ? '0 : w_ext;

   genvar gi;
   for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_mask[gi]          = (4'(gi) < w_sel_bytes);
      assign w_ext[gi*8 +: 8]    = (4'(gi) < w_ld_bytes) ? w_val[gi*8 +: 8] : {8{w_sign}};
   end

   // Pick the sign bit at the top of the loaded field.
   always_comb begin
      w_sign_bit = w_val[DATA_WIDTH-1];
      case (r_size)
         2'd0:    w_sign_bit = w_val[7];
         2'd1:    w_sign_bit = w_val[15];
         2'd2:    w_sign_bit = w_val[31];
         default: ;
      endcase
   end

   // Memory port: byte-enabled write, registered read, low-word capture in SPLIT.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < int'(NB); b++)
         if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      if (w_rd_en) r_rdata <= r_mem[w_idx];
      if (!w_idle && !r_we) r_lo <= r_rdata;
   end

   // FSM next state and ready; ready depends on state alone.
   always_comb begin
      w_state_next = r_state;
      ready_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (w_acc && w_split && !w_fault) w_state_next = S_SPLIT;
         end
         S_SPLIT: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control state, request latches and response pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_fault   <= 1'b0;
         r_split   <= 1'b0;
         r_size    <= 2'd0;
         r_off     <= '0;
         r_idx     <= '0;
         r_wd      <= '0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rd_hold <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_acc) begin
            r_we    <= we_i;
            r_uns   <= unsigned_i;
            r_size  <= size_i;
            r_off   <= w_off_in;
            r_idx   <= w_in_idx;
            r_wd    <= wd_i;
            r_fault <= w_fault;
            r_split <= w_split && !w_fault;
         end
         r_rvalid <= (w_acc && !we_i && (w_fault || !w_split)) || (!w_idle && !r_we);
         r_err    <= w_acc && w_fault;
         if (r_rvalid) r_rd_hold <= w_ld_data;
      end
   end

   assign rvalid_o = r_rvalid;
   assign err_o    = r_err;
   assign rd_o     = r_rvalid ? w_ld_data : r_rd_hold;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed scoreboard bench for a 32-bit and a 64-bit
// instance. The driver pushes each expected response into a per-instance
// queue; a negedge monitor pops and compares whenever rvalid_o or err_o fires.
module tb_data_memory_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req32 = 0, we32 = 0, uns32 = 0;
   logic [1:0]  size32 = 0;
   logic [31:0] addr32 = 0, wd32 = 0;
   logic        ready32, rvalid32, err32;
   logic [31:0] rd32;

   logic        req64 = 0, we64 = 0, uns64 = 0;
   logic [1:0]  size64 = 0;
   logic [31:0] addr64 = 0;
   logic [63:0] wd64 = 0;
   logic        ready64, rvalid64, err64;
   logic [63:0] rd64;

   data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH_BYTES(32'h20000), .START_ADDRESS(0), .INIT_FILE("")) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req32), .we_i(we32), .size_i(size32),
      .unsigned_i(uns32), .addr_i(addr32), .wd_i(wd32), .ready_o(ready32),
      .rvalid_o(rvalid32), .rd_o(rd32), .err_o(err32));

   data_memory_ctrl #(.DATA_WIDTH(64), .DEPTH_BYTES(32'h1000), .START_ADDRESS(0), .INIT_FILE("")) u_dut64 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req64), .we_i(we64), .size_i(size64),
      .unsigned_i(uns64), .addr_i(addr64), .wd_i(wd64), .ready_o(ready64),
      .rvalid_o(rvalid64), .rd_o(rd64), .err_o(err64));

   typedef struct {
      logic        is_load;
      logic        err;
      logic [63:0] data;
      int          due;
      string       name;
   } exp_t;

   exp_t q [2][$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", nm, act, req);
   endfunction

   // Monitor: compare every response against the oldest expectation.
   always @(negedge clk) begin : mon
      exp_t        e;
      logic        rv, er;
      logic [63:0] rd;
      if (rst_n) begin
         for (int s = 0; s < 2; s++) begin
            rv = (s == 1) ? rvalid64 : rvalid32;
            er = (s == 1) ? err64 : err32;
            rd = (s == 1) ? rd64 : {32'd0, rd32};
            if (rv || er) begin
               if (q[s].size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_resp dut%0d: rvalid=%b err=%b rd=%h, required no response", s, rv, er, rd);
               end else begin
                  e = q[s].pop_front();
                  check({e.name, "_rvalid"}, 64'(rv), 64'(e.is_load));
                  check({e.name, "_err"}, 64'(er), 64'(e.err));
                  if (e.is_load) check({e.name, "_rd"}, rd, e.data);
                  check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
               end
            end else if (q[s].size() > 0 && cyc > q[s][0].due) begin
               e = q[s].pop_front();
               n_checks++;
               $display("FAIL %s_timeout: no response at cycle %0d, required one by cycle %0d", e.name, cyc, e.due);
            end
         end
      end
   end

   // Drive one request from a negedge; returns at the negedge after acceptance.
   task automatic issue(input bit s, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [63:0] d, input bit resp,
                        input logic [63:0] xd, input logic xe, input int lat, input string nm);
      exp_t e;
      int   waited = 0;
      $display("txn %s dut%0d we=%b size=%0d uns=%b addr=%h wd=%h", nm, s, we, sz, uns, a, d);
      if (s) begin req64 = 1; we64 = we; size64 = sz; uns64 = uns; addr64 = a; wd64 = d; end
      else   begin req32 = 1; we32 = we; size32 = sz; uns32 = uns; addr32 = a; wd32 = d[31:0]; end
      while (!(s ? ready64 : ready32) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         n_checks++;
         $display("FAIL %s_accept: ready_o 0 for %0d cycles, required 1", nm, waited);
         req32 = 0; req64 = 0;
         return;
      end
      if (resp) begin
         e.is_load = !we; e.err = xe; e.data = xd; e.due = cyc + lat; e.name = nm;
         q[s].push_back(e);
      end
      @(negedge clk);
      if (s) req64 = 0; else req32 = 0;
   endtask

   task automatic st(input bit s, input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d, input string nm);
      issue(s, 1'b1, sz, 1'b0, a, d, 1'b0, 64'd0, 1'b0, 0, nm);
   endtask

   task automatic ld(input bit s, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [63:0] x, input int lat, input string nm);
      issue(s, 1'b0, sz, uns, a, 64'd0, 1'b1, x, 1'b0, lat, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready32", 64'(ready32), 64'd1);
      check("rst_rvalid32", 64'(rvalid32), 64'd0);
      check("rst_rd32", 64'(rd32), 64'd0);
      check("rst_err32", 64'(err32), 64'd0);
      check("rst_ready64", 64'(ready64), 64'd1);
      check("rst_rd64", rd64, 64'd0);
      rst_n = 1;

      // Aligned word/byte access
      st(0, 2, 32'h100, 64'hDEADBEEF, "sw_dead");
      ld(0, 2, 0, 32'h100, 64'hDEADBEEF, 1, "lw_dead");
      ld(0, 0, 0, 32'h103, 64'hFFFFFFDE, 1, "lb_103");
      ld(0, 0, 1, 32'h103, 64'h000000DE, 1, "lbu_103");

      // Half store into an existing word
      st(0, 2, 32'h100, 64'h11223344, "sw_1122");
      st(0, 1, 32'h102, 64'h8001, "sh_8001");
      ld(0, 2, 0, 32'h100, 64'h80013344, 1, "lw_merged");
      ld(0, 1, 0, 32'h102, 64'hFFFF8001, 1, "lh_102");
      ld(0, 1, 1, 32'h102, 64'h00008001, 1, "lhu_102");

      // Split store over zeroed words
      st(0, 2, 32'h100, 64'h0, "clr_100");
      st(0, 2, 32'h104, 64'h0, "clr_104");
      st(0, 2, 32'h101, 64'hAABBCCDD, "sw_split");
      check("split_ready_low", 64'(ready32), 64'd0);
      @(negedge clk);
      check("split_ready_back", 64'(ready32), 64'd1);
      ld(0, 2, 0, 32'h100, 64'hBBCCDD00, 1, "lw_100_lo");
      ld(0, 2, 0, 32'h104, 64'h000000AA, 1, "lw_104_hi");
      ld(0, 2, 0, 32'h101, 64'hAABBCCDD, 2, "lw_split");
      ld(0, 1, 0, 32'h103, 64'hFFFFAABB, 2, "lh_split");
      ld(0, 0, 1, 32'h104, 64'h000000AA, 1, "lbu_104");
      st(0, 2, 32'h105, 64'h99887766, "sw_split2");
      ld(0, 2, 0, 32'h108, 64'h00000099, 1, "lw_108_after_split");

      // Faults at the end of memory and illegal size
      st(0, 2, 32'h1FFFC, 64'h55667788, "sw_last");
      issue(0, 1'b0, 2, 1'b0, 32'h1FFFE, 64'd0, 1'b1, 64'd0, 1'b1, 1, "lw_fault_end");
      issue(0, 1'b1, 2, 1'b0, 32'h1FFFE, 64'h12345678, 1'b1, 64'd0, 1'b1, 1, "sw_fault_end");
      ld(0, 2, 0, 32'h1FFFC, 64'h55667788, 1, "lw_last_kept");
      issue(0, 1'b0, 3, 1'b0, 32'h100, 64'd0, 1'b1, 64'd0, 1'b1, 1, "ld_size3_fault");
      issue(0, 1'b1, 3, 1'b0, 32'h200, 64'hFFFFFFFF, 1'b1, 64'd0, 1'b1, 1, "sd_size3_fault");
      ld(0, 2, 0, 32'h200, 64'h0, 1, "lw_200_kept");
      ld(0, 1, 0, 32'h1FFFE, 64'h00005566, 1, "lh_last");
      issue(0, 1'b0, 1, 1'b0, 32'h1FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1, "lh_fault_straddle_end");
      ld(0, 0, 0, 32'h1FFFF, 64'h00000055, 1, "lb_last");

      // Reset while a split store is in SPLIT
      st(0, 2, 32'hFC, 64'h11111111, "sw_fc");
      st(0, 2, 32'h100, 64'h22222222, "sw_100");
      st(0, 2, 32'hFE, 64'hAABBCCDD, "sw_split_rst");
      rst_n = 0;
      #1;
      check("rst_split_ready", 64'(ready32), 64'd1);
      check("rst_split_rvalid", 64'(rvalid32), 64'd0);
      check("rst_split_rd", 64'(rd32), 64'd0);
      @(negedge clk);
      rst_n = 1;
      ld(0, 2, 0, 32'hFC, 64'hCCDD1111, 1, "lw_fc_low_kept");
      ld(0, 2, 0, 32'h100, 64'h22222222, 1, "lw_100_high_lost");

      // Reset while a split load is in SPLIT: no response allowed
      issue(0, 1'b0, 2, 1'b0, 32'h101, 64'd0, 1'b0, 64'd0, 1'b0, 0, "lw_split_rst");
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         check("rst_load_no_rvalid", 64'(rvalid32), 64'd0);
         @(negedge clk);
      end

      // 64-bit instance
      st(1, 3, 32'h8, 64'h0123456789ABCDEF, "sd_8");
      ld(1, 3, 0, 32'h8, 64'h0123456789ABCDEF, 1, "ld_8");
      ld(1, 2, 0, 32'hC, 64'h0000000001234567, 1, "lw_c");
      ld(1, 0, 0, 32'hF, 64'h0000000000000001, 1, "lb_f");
      ld(1, 1, 0, 32'hE, 64'h0000000000000123, 1, "lh_e");
      ld(1, 2, 0, 32'hE, 64'h0000000000000123, 2, "lw_e_split");
      st(1, 3, 32'h14, 64'hFEDCBA9876543210, "sd_split");
      ld(1, 3, 0, 32'h14, 64'hFEDCBA9876543210, 2, "ld_split");
      ld(1, 2, 0, 32'h18, 64'hFFFFFFFFFEDCBA98, 1, "lw_18");
      ld(1, 2, 1, 32'h18, 64'h00000000FEDCBA98, 1, "lwu_18");
      ld(1, 3, 0, 32'h10, 64'h7654321000000000, 1, "ld_10");
      issue(1, 1'b0, 3, 1'b0, 32'hFFC, 64'd0, 1'b1, 64'd0, 1'b1, 1, "ld_fault_end64");

      repeat (5) @(negedge clk);
      check("q32_drained", 64'(q[0].size()), 64'd0);
      check("q64_drained", 64'(q[1].size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
